// File: rtl/nanomamba_fe_pkg.sv
// Shared constants, types and default filter layout for the
// NanoMamba audio front end.
package nanomamba_fe_pkg;

  localparam int N_FFT_BINS = 129;
  localparam int N_MELS     = 40;
  localparam int PWR_WIDTH  = 24;
  localparam int ACC_WIDTH  = 32;
  localparam int OUT_SHIFT  = 16;
  localparam int WT_WIDTH   = 8;
  localparam int BAND_WIDTH = 6;
  localparam int COEF_WIDTH = BAND_WIDTH + WT_WIDTH;

  localparam logic [5:0] BAND_SKIP = 6'd63;

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Q8 band position advance per FFT bin for the power-up layout
  localparam int DEF_STEP = (N_MELS * 256) / N_FFT_BINS;

  typedef struct packed {
    logic [BAND_WIDTH-1:0] band;
    logic [WT_WIDTH-1:0]   wt;
  } coef_t;

  function automatic coef_t default_coef(input logic [7:0] bin);
    logic [13:0] pos;
    coef_t c;
    pos    = 14'(bin) * 14'(DEF_STEP);
    c.band = pos[13:8];
    c.wt   = 8'd255 - pos[7:0];
    return c;
  endfunction

endpackage

// File: rtl/nanomamba_mel_filterbank_if.sv
// Power-bin stream, coefficient write port and mel output
// stream of the mel filterbank.
interface nanomamba_mel_filterbank_if;
  import nanomamba_fe_pkg::*;

  logic [PWR_WIDTH-1:0] pwr_in;
  logic [7:0]           pwr_bin;
  logic                 pwr_valid;
  logic                 pwr_last;
  logic                 pwr_ready;

  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [5:0]           cfg_band;
  logic [7:0]           cfg_wt;

  logic [15:0]          mel_out;
  logic [5:0]           mel_index;
  logic                 mel_valid;
  logic                 mel_frame_done;
  logic                 mel_sat;

  modport master (
    output pwr_in, pwr_bin, pwr_valid, pwr_last,
    output cfg_we, cfg_addr, cfg_band, cfg_wt,
    input  pwr_ready,
    input  mel_out, mel_index, mel_valid,
    input  mel_frame_done, mel_sat
  );

  modport slave (
    input  pwr_in, pwr_bin, pwr_valid, pwr_last,
    input  cfg_we, cfg_addr, cfg_band, cfg_wt,
    output pwr_ready,
    output mel_out, mel_index, mel_valid,
    output mel_frame_done, mel_sat
  );

endinterface

// File: rtl/nanomamba_mel_coef_rom.sv
// Per-bin filter coefficient table: one synchronous read port,
// one write port, powers up holding the default layout.
module nanomamba_mel_coef_rom
  import nanomamba_fe_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  coef_t      wdata,
  input  logic [7:0] raddr,
  output coef_t      rdata
);

  // Held as a delta from the default layout, so a zero-filled
  // array at power-up reads back as that layout.
  coef_t mem [N_FFT_BINS];

  always_ff @(posedge clk) begin
    if (we && waddr < 8'(N_FFT_BINS))
      mem[waddr] <= wdata ^ default_coef(waddr);
    rdata <= mem[raddr] ^ default_coef(raddr);
  end

endmodule

// File: rtl/nanomamba_mel_filterbank.sv
// Streaming triangular mel filterbank: 2-stage MAC into a
// saturating band accumulator array, then 40-band drain.
module nanomamba_mel_filterbank
  import nanomamba_fe_pkg::*;
(
  input logic clk,
  input logic rst_n,
  nanomamba_mel_filterbank_if.slave bus
);

  localparam int PW = PWR_WIDTH + 9;
  localparam int SW = ACC_WIDTH + 2;

  logic [1:0]           state;
  logic [5:0]           idx;
  logic                 sticky;
  logic [ACC_WIDTH-1:0] acc [N_MELS];

  logic                 take;
  logic                 s1_vld;
  logic [PWR_WIDTH-1:0] s1_pwr;
  coef_t                coef;
  coef_t                cfg_coef;

  logic [5:0]           band_hi;
  logic                 hit_lo, hit_hi;
  logic                 sat_lo, sat_hi;
  logic [PW-1:0]        prod_lo, prod_hi;
  logic [SW-1:0]        sum_lo, sum_hi;
  logic [ACC_WIDTH-1:0] nxt_lo, nxt_hi;
  logic [ACC_WIDTH-1:0] mel_raw;

  assign take     = bus.pwr_valid & bus.pwr_ready;
  assign cfg_coef = '{band: bus.cfg_band, wt: bus.cfg_wt};

  nanomamba_mel_coef_rom u_rom (
    .clk   (clk),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wdata (cfg_coef),
    .raddr (bus.pwr_bin),
    .rdata (coef)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pwr <= '0;
    end else begin
      s1_vld <= take && bus.pwr_bin < 8'(N_FFT_BINS);
      if (take)
        s1_pwr <= bus.pwr_in;
    end
  end

  always_comb begin
    band_hi = coef.band + 6'd1;
    hit_lo  = s1_vld && coef.band != BAND_SKIP
              && coef.band < 6'(N_MELS);
    hit_hi  = hit_lo && coef.band != 6'(N_MELS - 1);
    prod_lo = PW'(s1_pwr) * PW'(coef.wt);
    prod_hi = PW'(s1_pwr) * (PW'(9'd256) - PW'(coef.wt));
    sum_lo  = SW'(acc[coef.band]) + SW'(prod_lo);
    sum_hi  = SW'(acc[band_hi]) + SW'(prod_hi);
    sat_lo  = |sum_lo[SW-1:ACC_WIDTH];
    sat_hi  = |sum_hi[SW-1:ACC_WIDTH];
    nxt_lo  = sat_lo ? '1 : sum_lo[ACC_WIDTH-1:0];
    nxt_hi  = sat_hi ? '1 : sum_hi[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_MELS; i++)
        acc[i] <= '0;
    end else begin
      for (int i = 0; i < N_MELS; i++) begin
        if (state == S_DONE)
          acc[i] <= '0;
        else if (hit_lo && coef.band == 6'(i))
          acc[i] <= nxt_lo;
        else if (hit_hi && band_hi == 6'(i))
          acc[i] <= nxt_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_ACCUM;
      idx    <= '0;
      sticky <= 1'b0;
    end else begin
      if (state == S_DONE)
        sticky <= 1'b0;
      else if ((hit_lo && sat_lo) || (hit_hi && sat_hi))
        sticky <= 1'b1;
      unique case (state)
        S_ACCUM:
          if (take && bus.pwr_last)
            state <= S_DRAIN;
        S_DRAIN: begin
          state <= S_OUTPUT;
          idx   <= '0;
        end
        S_OUTPUT:
          if (idx == 6'(N_MELS - 1))
            state <= S_DONE;
          else
            idx <= idx + 6'd1;
        S_DONE: begin
          state <= S_ACCUM;
          idx   <= '0;
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

  assign mel_raw = acc[idx] >> OUT_SHIFT;

  assign bus.pwr_ready      = state == S_ACCUM;
  assign bus.mel_valid      = state == S_OUTPUT;
  assign bus.mel_index      = idx;
  assign bus.mel_frame_done = state == S_DONE;
  assign bus.mel_sat        = (state == S_DONE) & sticky;
  assign bus.mel_out        = !bus.mel_valid ? 16'd0 :
                              |mel_raw[ACC_WIDTH-1:16] ? 16'hFFFF :
                              mel_raw[15:0];

endmodule

// File: doc/nanomamba_mel_filterbank.md
Name: nanomamba_mel_filterbank

Overview:
Streaming triangular mel filterbank directly upstream of the DualPCEN stage. It accepts one frame of FFT power-spectrum bins and accumulates each bin into its two neighbouring mel bands with complementary Q0.8 weights. It then streams 40 linear-energy mel values, using the same mel_out/mel_index/mel_valid/mel_frame_done contract the PCEN stage buffers in its IDLE state. Filter layout lives in a writable per-bin coefficient table.

Parameters:
N_FFT_BINS, 129, power bins per frame (256-pt FFT)
N_MELS, 40, mel bands
PWR_WIDTH, 24, unsigned power-bin width
ACC_WIDTH, 32, per-band accumulator width (saturating)
OUT_SHIFT, 16, right shift from accumulator to 16-bit mel output

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
pwr_in  in  PWR_WIDTH  power of bin pwr_bin
pwr_bin  in  8  bin index
pwr_valid  in  1  bin present
pwr_last  in  1  last bin of frame (qualified by pwr_valid & pwr_ready)
pwr_ready  out  1  block accepting bins
cfg_we  in  1  coefficient write strobe
cfg_addr  in  8  bin to configure
cfg_band  in  6  lower band for bin; 63 = bin unused
cfg_wt  in  8  lower-band weight, Q0.8
mel_out  out  16  mel energy, linear
mel_index  out  6  band index 0..N_MELS-1
mel_valid  out  1  mel_out valid
mel_frame_done  out  1  one-cycle end-of-frame pulse
mel_sat  out  1  any accumulator saturated this frame; valid with mel_frame_done

Behaviour:
- Reset (async): state=S_ACCUM, all accumulators 0, pwr_ready=1, mel_out=0, mel_index=0, mel_valid=0, mel_frame_done=0, mel_sat=0, saturation sticky=0. Coefficient table is NOT reset; it powers up with the default 40-band mel layout.
- States: S_ACCUM, S_DRAIN, S_OUTPUT, S_DONE.
- S_ACCUM: pwr_ready=1. A beat is accepted on pwr_valid & pwr_ready.
  - Stage 1: coefficient table read (band b, weight w); pwr registered.
  - Stage 2: acc[b] += pwr*w; acc[b+1] += pwr*(256-w).
- Products: PWR_WIDTH+9 bits. Sums saturate at 2^ACC_WIDTH-1 and set the sticky flag.
- Same band on back-to-back beats: no hazard, because the accumulators are a register array updated in stage 2.
- Skip conditions:
  - pwr_bin >= N_FFT_BINS: beat ignored.
  - b >= N_MELS (incl. 63): beat ignored.
  - b = N_MELS-1: upper contribution dropped.
- Bins may arrive in any order. Duplicate bins accumulate twice.
- Accepted beat with pwr_last: S_DRAIN for 1 cycle (stage 2 completes), pwr_ready=0.
- S_OUTPUT:
  - One band per cycle, index 0..N_MELS-1.
  - mel_out = min(acc>>OUT_SHIFT, 0xFFFF); mel_index=i; mel_valid=1.
  - No backpressure.
  - First mel_valid occurs 2 cycles after the pwr_last beat is accepted.
- S_DONE (cycle after index N_MELS-1):
  - mel_frame_done=1, mel_sat=sticky.
  - Clear accumulators and sticky; return to S_ACCUM.
  - pwr_ready is 0 for N_MELS+2 cycles total per frame turnaround.
- pwr_valid while pwr_ready=0: ignored, no buffering. Upstream holds the beat.
- cfg_we: writes table entry {cfg_band,cfg_wt} at cfg_addr, any state.
  - Same-cycle read of the same address returns the old entry.
  - cfg_addr >= N_FFT_BINS is ignored.
  - Reconfiguration mid-frame is the software's responsibility; no interlock.
- Reset mid-frame or mid-output: partial frame discarded; no further mel_valid/mel_frame_done.
- Frame spacing: the 10 ms hop guarantees the PCEN stage is back in IDLE before the next frame's outputs.

Decomposition:
- Package nanomamba_fe_pkg:
  - N_MELS, N_FFT_BINS, BAND_SKIP=6'd63, weight width 8, PWR/ACC widths.
  - State encodings.
  - Default mel-layout constants/mem-file name.
- Sub-module nanomamba_mel_coef_rom: N_FFT_BINS x 14-bit table, synchronous read port, single write port, default-layout initialisation.
- Top holds the FSM, 2-stage MAC and accumulator array.

Test Plan:
1. Single bin: cfg bin10 -> band3, wt=192. Frame = bin10 pwr=0x10000 with last -> mel3=192, mel4=64, all other bands 0. mel_frame_done one cycle after index 39; mel_sat=0.
2. Saturation: all 129 bins band0 wt=255, pwr=0xFFFFFF -> mel0=0xFFFF, mel_sat=1. Next all-zero frame -> mel_sat=0 and all mel=0 (clear check).
3. Backpressure: hold pwr_valid=1 through turnaround -> pwr_ready=0 for 42 cycles, no accumulation during that window. First mel_valid exactly 2 cycles after the last beat.
4. Skip paths: bin10 band=63; pwr_bin=200; band39 wt=100 pwr=0x10000 -> mel39=100, no spill, all others 0.
5. Reset mid-frame: rst_n low after 50 bins, then a full frame from test 1 -> output identical to test 1, and no output for the aborted frame.
6. Back-to-back same band on consecutive cycles: bins 10,11 both band3 wt=128, pwr=0x10000 -> mel3=256, mel4=256.
